// File: rtl/coproc_pkg.sv
// Shared geometry and state encoding for the boot row loader.
// The row register is filled one 12-bit pixel at a time, from a byte stream packed 3 bytes -> 2 pixels.
package coproc_pkg;

    localparam int IMG_W         = 256;
    localparam int PIX_W         = 12;
    localparam int ROW_W         = IMG_W * PIX_W;
    localparam int ADDR_W        = 9;
    localparam int BYTES_PER_ROW = ROW_W / 8;
    localparam int ROWS_W        = ADDR_W + 1;
    localparam int PIXCNT_W      = $clog2(IMG_W);
    localparam int MAX_ROWS      = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        FIN
    } loader_state_t;

    // A load never covers more rows than the two image slots hold.
    function automatic logic [ROWS_W-1:0] sat_rows(input logic [ROWS_W-1:0] n);
        return (n > ROWS_W'(MAX_ROWS)) ? ROWS_W'(MAX_ROWS) : n;
    endfunction

endpackage

// File: rtl/boot_row_loader_if.sv
// Host-side control, byte stream and boot write port of the row loader.
interface boot_row_loader_if;
    import coproc_pkg::*;

    logic                start;
    logic [ADDR_W-1:0]   base_row;
    logic [ADDR_W:0]     row_count;
    logic [7:0]          byte_in;
    logic                byte_valid;
    logic                byte_ready;
    logic                we_boot;
    logic [ROW_W-1:0]    wdata_boot;
    logic [ADDR_W-1:0]   waddr_boot;
    logic                bootloading;
    logic                busy;
    logic                done;

    modport master (
        output start, base_row, row_count, byte_in, byte_valid,
        input  byte_ready, we_boot, wdata_boot, waddr_boot, bootloading, busy, done
    );

    modport slave (
        input  start, base_row, row_count, byte_in, byte_valid,
        output byte_ready, we_boot, wdata_boot, waddr_boot, bootloading, busy, done
    );

endinterface

// File: rtl/boot_row_loader_pix_unpack.sv
// Unpacks accepted bytes into 12-bit pixels: p_even = {b0, b1[7:4]}, p_odd = {b1[3:0], b2}.
// Pixels are presented combinationally in the cycle their completing byte is accepted.
module pix_unpack
    import coproc_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_byte,
    input  logic             i_accept,
    input  logic             i_clear,
    output logic             o_pix_valid,
    output logic [PIX_W-1:0] o_pix
);

    logic [1:0]       r_phase;
    logic [PIX_W-1:0] r_stash;

    // Stash keeps b0 in [11:4] and the low nibble of b1 in [3:0] across stream gaps.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_phase <= '0;
            r_stash <= '0;
        end else if (i_accept) begin
            case (r_phase)
                2'd0: begin
                    r_stash[11:4] <= i_byte;
                    r_phase       <= 2'd1;
                end
                2'd1: begin
                    r_stash[3:0] <= i_byte[3:0];
                    r_phase      <= 2'd2;
                end
                default: r_phase <= 2'd0;
            endcase
        end
    end

    always_comb begin
        o_pix_valid = i_accept && (r_phase != 2'd0);
        o_pix       = (r_phase == 2'd1) ? {r_stash[11:4], i_byte[7:4]}
                                        : {r_stash[3:0], i_byte};
    end

endmodule

// File: rtl/boot_row_loader.sv
// Assembles 256-pixel rows from the packed byte stream and issues one boot write per row,
// holding bootloading/busy for the whole framed load.
module boot_row_loader
    import coproc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    boot_row_loader_if.slave bus
);

    loader_state_t         r_state;
    loader_state_t         w_state_next;
    logic [ADDR_W-1:0]     r_addr;
    logic [ROWS_W-1:0]     r_rows_left;
    logic [PIXCNT_W-1:0]   r_pix_cnt;
    logic [ROW_W-1:0]      r_row;
    logic                  r_we;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_start_ok;
    logic                  w_clear;
    logic                  w_pix_valid;
    logic [PIX_W-1:0]      w_pix;
    logic                  w_row_full;

    assign bus.byte_ready = (r_state == LOAD);
    assign w_accept       = bus.byte_valid && (r_state == LOAD);
    assign w_start_ok     = bus.start && (r_state == IDLE);
    assign w_clear        = w_start_ok || (r_state == WRITE);
    assign w_row_full     = w_pix_valid && (r_pix_cnt == PIXCNT_W'(IMG_W - 1));

    pix_unpack u_unpack (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_byte      (bus.byte_in),
        .i_accept    (w_accept),
        .i_clear     (w_clear),
        .o_pix_valid (w_pix_valid),
        .o_pix       (w_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = (bus.row_count == '0) ? FIN : LOAD;
            LOAD:    if (w_row_full) w_state_next = WRITE;
            WRITE:   w_state_next = (r_rows_left == ROWS_W'(1)) ? FIN : LOAD;
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the strobe lines up with the WRITE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_rows_left <= '0;
            r_pix_cnt   <= '0;
            r_row       <= '0;
        end else begin
            r_we   <= (w_state_next == WRITE);
            r_busy <= (w_state_next != IDLE);
            r_done <= (r_state == FIN);

            if (w_start_ok) begin
                r_addr      <= bus.base_row;
                r_rows_left <= sat_rows(bus.row_count);
            end else if (r_state == WRITE) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_rows_left <= r_rows_left - ROWS_W'(1);
            end

            if (w_clear)          r_pix_cnt <= '0;
            else if (w_pix_valid) r_pix_cnt <= r_pix_cnt + PIXCNT_W'(1);

            if (w_pix_valid) r_row[r_pix_cnt*PIX_W +: PIX_W] <= w_pix;
        end
    end

    assign bus.we_boot     = r_we;
    assign bus.wdata_boot  = r_row;
    assign bus.waddr_boot  = r_addr;
    assign bus.bootloading = r_busy;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule

// File: tb/tb_boot_row_loader.sv
// Directed bench for boot_row_loader: expected rows are built from the driven bytes and
// queued, then popped and compared whenever the loader strobes a boot write.
module tb_boot_row_loader;
    import coproc_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  row;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    boot_row_loader_if bus();

    boot_row_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_writes = 0;
    int n_done   = 0;
    int we_cyc   = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    logic [ROW_W-1:0] last_row;
    logic [ROW_W-1:0] row1;
    exp_t sb[$];
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // Write/done monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.we_boot) begin
            n_writes++;
            we_cyc   = cyc;
            last_row = bus.wdata_boot;
            check("ready_low_in_write", 64'(bus.byte_ready), 64'(0));
            check("bootld_in_write", 64'(bus.bootloading), 64'(1));
            check("sb_has_entry", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                int bad;
                mon_e = sb.pop_front();
                check("waddr", 64'(bus.waddr_boot), 64'(mon_e.addr));
                bad = -1;
                for (int i = 0; i < IMG_W; i++)
                    if (bad < 0 && bus.wdata_boot[i*PIX_W +: PIX_W] !== mon_e.row[i*PIX_W +: PIX_W])
                        bad = i;
                n_checks++;
                assert (bus.wdata_boot === mon_e.row) n_pass++;
                else $error("FAIL row addr=%0d first_bad_pixel=%0d observed=%h expected=%h",
                            mon_e.addr, bad, bus.wdata_boot[bad*PIX_W +: PIX_W],
                            mon_e.row[bad*PIX_W +: PIX_W]);
            end
        end
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_row  = base;
        bus.row_count = cnt;
        start_cyc     = cyc;
        check("idle_before_start", 64'(bus.bootloading), 64'(0));
        @(negedge clk);
        bus.start = 1'b0;
        check("bootld_after_start", 64'(bus.bootloading), 64'(1));
        check("busy_after_start", 64'(bus.busy), 64'(1));
    endtask

    // mode 0: AB CD EF pattern, mode 1: random bytes.
    task automatic send_row(input logic [ADDR_W-1:0] addr, input int mode, input bit throttle,
                            input int stall_at, input int n_bytes, input int mid_at);
        logic [7:0] b [BYTES_PER_ROW];
        logic [7:0] pat [3];
        logic [7:0] b0, b1, b2;
        exp_t e;
        bit accepted;
        bit pulsed;
        int waited;
        pat = '{8'hAB, 8'hCD, 8'hEF};
        pulsed = 1'b0;
        for (int j = 0; j < BYTES_PER_ROW; j++)
            b[j] = (mode == 0) ? pat[j % 3] : 8'($urandom_range(0, 255));
        e.addr = addr;
        for (int k = 0; k < IMG_W / 2; k++) begin
            b0 = b[3*k];
            b1 = b[3*k+1];
            b2 = b[3*k+2];
            e.row[24*k +: 12]      = {b0, b1[7:4]};
            e.row[24*k + 12 +: 12] = {b1[3:0], b2};
        end
        for (int j = 0; j < n_bytes; j++) begin
            if (j == stall_at)
                repeat (10) begin
                    @(negedge clk);
                    bus.byte_valid = 1'b0;
                end
            accepted = 1'b0;
            waited   = 0;
            while (!accepted && waited < 2000) begin
                @(negedge clk);
                bus.start = 1'b0;
                if (j == mid_at && !pulsed) begin
                    bus.start     = 1'b1;
                    bus.base_row  = 9'd77;
                    bus.row_count = 10'd3;
                    pulsed        = 1'b1;
                end
                bus.byte_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.byte_in    = b[j];
                if (bus.byte_valid && bus.byte_ready) accepted = 1'b1;
                else waited++;
            end
            if (!accepted) begin
                check("byte_accept_timeout", 64'(accepted), 64'(1));
                finish_run();
            end
            if (j == BYTES_PER_ROW - 1) sb.push_back(e);
        end
    endtask

    task automatic idle_bus();
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget);
        int w;
        w = 0;
        while (n_done == n0 && w < budget) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("done_seen", 64'(n_done - n0), 64'(1));
    endtask

    initial begin
        int n0, w0;
        rst = 1'b1;
        bus.start = 1'b0; bus.base_row = '0; bus.row_count = '0;
        bus.byte_in = '0; bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", 64'(bus.we_boot), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_bootld", 64'(bus.bootloading), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_ready", 64'(bus.byte_ready), 64'(0));
        check("rst_waddr", 64'(bus.waddr_boot), 64'(0));
        check("rst_row_zero", 64'(bus.wdata_boot == '0), 64'(1));
        rst = 1'b0;
        bus.byte_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("no_start_stalls", 64'(bus.byte_ready), 64'(0));
        bus.byte_valid = 1'b0;

        // single row, pattern
        n0 = n_done; w0 = n_writes;
        do_start(9'd0, 10'd1);
        send_row(9'd0, 0, 1'b0, -1, BYTES_PER_ROW, -1);
        idle_bus();
        wait_done(n0, 50);
        check("t1_writes", 64'(n_writes - w0), 64'(1));
        check("t1_done_latency", 64'(done_cyc - we_cyc), 64'(2));
        check("t1_pix0", 64'(last_row[11:0]), 64'(12'hABC));
        check("t1_pix1", 64'(last_row[23:12]), 64'(12'hDEF));
        check("t1_pix255", 64'(last_row[ROW_W-1 -: 12]), 64'(12'hDEF));
        check("t1_idle_after_done", 64'(bus.busy), 64'(0));
        row1 = last_row;

        // multi-row throttled load into the upper slot
        n0 = n_done; w0 = n_writes;
        do_start(9'd256, 10'd16);
        for (int r = 0; r < 16; r++)
            send_row(9'(256 + r), 1, 1'b1, -1, BYTES_PER_ROW, -1);
        idle_bus();
        wait_done(n0, 50);
        check("t2_writes", 64'(n_writes - w0), 64'(16));
        repeat (5) @(negedge clk);
        check("t2_single_done", 64'(n_done - n0), 64'(1));

        // address wrap
        n0 = n_done; w0 = n_writes;
        do_start(9'd510, 10'd4);
        for (int r = 0; r < 4; r++)
            send_row(9'((510 + r) % 512), 1, 1'b0, -1, BYTES_PER_ROW, -1);
        idle_bus();
        wait_done(n0, 50);
        check("t3_writes", 64'(n_writes - w0), 64'(4));

        // zero rows
        n0 = n_done; w0 = n_writes;
        do_start(9'd3, 10'd0);
        wait_done(n0, 20);
        check("t4_zero_done_latency", 64'(done_cyc - start_cyc), 64'(2));
        check("t4_zero_no_write", 64'(n_writes - w0), 64'(0));

        // start while busy must not disturb address or row count
        n0 = n_done; w0 = n_writes;
        do_start(9'd5, 10'd1);
        send_row(9'd5, 1, 1'b0, -1, BYTES_PER_ROW, 100);
        idle_bus();
        wait_done(n0, 50);
        check("t4_busy_start_writes", 64'(n_writes - w0), 64'(1));
        repeat (3) @(negedge clk);
        check("t4_busy_start_idle", 64'(bus.busy), 64'(0));

        // reset mid-row
        n0 = n_done; w0 = n_writes;
        do_start(9'd100, 10'd1);
        send_row(9'd100, 1, 1'b0, -1, 200, -1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_we", 64'(bus.we_boot), 64'(0));
        check("t5_rst_bootld", 64'(bus.bootloading), 64'(0));
        check("t5_rst_busy", 64'(bus.busy), 64'(0));
        check("t5_rst_row_zero", 64'(bus.wdata_boot == '0), 64'(1));
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_rst_no_done", 64'(n_done - n0), 64'(0));
        check("t5_rst_no_write", 64'(n_writes - w0), 64'(0));
        n0 = n_done;
        do_start(9'd7, 10'd1);
        send_row(9'd7, 1, 1'b0, -1, BYTES_PER_ROW, -1);
        idle_bus();
        wait_done(n0, 50);

        // stall between b1 and b2 of the second pixel pair
        n0 = n_done;
        do_start(9'd9, 10'd1);
        send_row(9'd9, 0, 1'b0, 5, BYTES_PER_ROW, -1);
        idle_bus();
        wait_done(n0, 50);
        check("t6_stall_matches_unstalled", 64'(last_row === row1), 64'(1));

        check("sb_drained", 64'(sb.size()), 64'(0));
        check("total_done", 64'(n_done), 64'(7));
        finish_run();
    end

    initial begin
        #5_000_000;
        n_checks++;
        $display("FAIL watchdog observed=timeout expected=completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
